// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared encodings for the program-counter sequencer
//
// Purpose: opcode constants, PC mux select encodings, FSM state encodings,
// the packed control-strobe bundle and a small opcode classification helper.
// Ports: none (package).

package risc_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Opcodes; any value not listed here executes as NOP
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_CALL = 4'h7;
  localparam logic [3:0] OP_RET  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // PC mux select encodings
  localparam logic [1:0] SEL_INC = 2'b00;  // PC+1
  localparam logic [1:0] SEL_BR  = 2'b01;  // branch target
  localparam logic [1:0] SEL_RET = 2'b10;  // ret_addr
  localparam logic [1:0] SEL_VEC = 2'b11;  // vector 0x00

  // Per-cycle control strobes produced by the sequencer
  typedef struct packed {
    logic       pccr;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       alu_en;
    logic       mem_req;
    logic       rf_we;
    logic       halted;
  } seq_ctrl_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address stack for CALL/RET
//
// Purpose: LIFO of return addresses; push has priority over pop.
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears count)
//   push, pop       stack operations (ignored when full / empty)
//   din             address pushed on push
//   top             top-of-stack entry, 0 when empty
//   full, empty     occupancy status

module ret_stack #(
  parameter int STK_DEPTH = 4,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int AW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [STK_DEPTH];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Count is one wider than the index so "full" is representable; the write
  // index wraps to 0 only when full, and pushes are blocked then.
  assign wr_idx = cnt_q[AW-1:0];
  assign rd_idx = AW'(cnt_q - CW'(1));
  assign full   = (cnt_q == CW'(STK_DEPTH));
  assign empty  = (cnt_q == '0);
  assign top    = empty ? '0 : mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem_q[wr_idx] <= din;
      cnt_q         <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction sequencer driving the ProgramCounter
//
// Purpose: FETCH/DECODE/EXEC/MEM/HALT control FSM producing PC load, PC mux
// select and datapath strobes, with a return-address stack for CALL/RET.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   opcode              instruction-register opcode (valid from DECODE)
//   zf, cf              ALU flags, sampled in EXEC
//   mem_ready           memory handshake completion
//   pc_cur              current ProgramCounter value
//   PCCR, pc_sel        PC load enable and mux select
//   ret_addr            top-of-stack return address (0x00 when empty)
//   ir_ld, alu_en, mem_req, rf_we   datapath strobes
//   halted, stk_err     status (stk_err sticky until reset)

module pc_sequencer
  import risc_pkg::*;
#(
  parameter int STK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zf,
  input  logic       cf,
  input  logic       mem_ready,
  input  logic [7:0] pc_cur,
  output logic       PCCR,
  output logic [1:0] pc_sel,
  output logic [7:0] ret_addr,
  output logic       ir_ld,
  output logic       alu_en,
  output logic       mem_req,
  output logic       rf_we,
  output logic       halted,
  output logic       stk_err
);

  logic [2:0] state_q, state_d;
  logic       stk_err_q, stk_err_d;
  logic       push, pop;
  logic       stk_full, stk_empty;
  logic [7:0] stk_top;
  logic [7:0] push_addr;
  seq_ctrl_t  ctrl_c;
  seq_ctrl_t  ctrl_o;

  // Natural 8-bit wrap gives 0xFF -> 0x00
  assign push_addr = pc_cur + 8'd1;

  ret_stack #(
    .STK_DEPTH(STK_DEPTH),
    .DW       (8)
  ) u_ret_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_addr),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );

  always_comb begin
    ctrl_c    = '0;
    state_d   = state_q;
    stk_err_d = stk_err_q;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_ld = 1'b1;
          state_d      = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d       = ST_FETCH;
        ctrl_c.pccr   = 1'b1;
        ctrl_c.pc_sel = SEL_INC;
        case (opcode)
          OP_ALU: begin
            ctrl_c.alu_en = 1'b1;
            ctrl_c.rf_we  = 1'b1;
          end
          OP_LD, OP_ST: begin
            // PC advances only once the memory access completes
            ctrl_c.pccr = 1'b0;
            state_d     = ST_MEM;
          end
          OP_JMP: ctrl_c.pc_sel = SEL_BR;
          OP_JZ:  ctrl_c.pc_sel = zf ? SEL_BR : SEL_INC;
          OP_JC:  ctrl_c.pc_sel = cf ? SEL_BR : SEL_INC;
          OP_CALL: begin
            if (stk_full) begin
              stk_err_d = 1'b1;
            end else begin
              push          = 1'b1;
              ctrl_c.pc_sel = SEL_BR;
            end
          end
          OP_RET: begin
            // ret_addr is the pre-pop top; the pop lands at the same edge
            // the PC loads it
            if (stk_empty) begin
              stk_err_d = 1'b1;
            end else begin
              pop           = 1'b1;
              ctrl_c.pc_sel = SEL_RET;
            end
          end
          OP_HLT: begin
            ctrl_c.pccr = 1'b0;
            state_d     = ST_HALT;
          end
          default: ;
        endcase
      end

      ST_MEM: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.pccr   = 1'b1;
          ctrl_c.pc_sel = SEL_INC;
          ctrl_c.rf_we  = (opcode == OP_LD);
          state_d       = ST_FETCH;
        end
      end

      ST_HALT: begin
        ctrl_c.halted = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stk_err_q <= stk_err_d;
    end
  end

  // Outputs are forced quiet while reset is held so an abandoned instruction
  // can never emit a PC load, whatever state the FSM was in.
  assign ctrl_o   = rst ? ctrl_c : '0;
  assign PCCR     = ctrl_o.pccr;
  assign pc_sel   = ctrl_o.pc_sel;
  assign ir_ld    = ctrl_o.ir_ld;
  assign alu_en   = ctrl_o.alu_en;
  assign mem_req  = ctrl_o.mem_req;
  assign rf_we    = ctrl_o.rf_we;
  assign halted   = ctrl_o.halted;
  assign stk_err  = rst & stk_err_q;
  assign ret_addr = rst ? stk_top : 8'h00;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zf, cf, mem_ready;
  logic [7:0] pc_cur;
  logic       PCCR;
  logic [1:0] pc_sel;
  logic [7:0] ret_addr;
  logic       ir_ld, alu_en, mem_req, rf_we, halted, stk_err;

  always #5 clk = ~clk;

  pc_sequencer #(.STK_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .zf       (zf),
    .cf       (cf),
    .mem_ready(mem_ready),
    .pc_cur   (pc_cur),
    .PCCR     (PCCR),
    .pc_sel   (pc_sel),
    .ret_addr (ret_addr),
    .ir_ld    (ir_ld),
    .alu_en   (alu_en),
    .mem_req  (mem_req),
    .rf_we    (rf_we),
    .halted   (halted),
    .stk_err  (stk_err)
  );

  typedef struct {
    logic [1:0] sel;
    logic       rf;
    logic       alu;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] stk_m[$];
  logic       err_m;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":outs"}, {PCCR, pc_sel, ir_ld, alu_en, mem_req, rf_we, halted, stk_err}, 0);
    check({tag, ":ret"}, ret_addr, 8'h00);
  endtask

  task automatic pccr_pop(input string tag);
    exp_t e;
    check({tag, ":pccr"}, PCCR, 1);
    check({tag, ":sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ":pc_sel"}, pc_sel, e.sel);
      check({tag, ":rf_we"}, rf_we, e.rf);
      check({tag, ":alu_en"}, alu_en, e.alu);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet({tag, ":in_reset"});
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check({tag, ":first_fetch"}, {mem_req, PCCR, halted}, 3'b100);
    stk_m.delete();
    err_m = 1'b0;
  endtask

  // One instruction, starting in its FETCH cycle
  task automatic do_instr(input string tag, input logic [3:0] op, input logic z, input logic c,
                          input logic [7:0] pc, input int waits,
                          input logic [1:0] esel, input logic erf, input logic ealu);
    exp_t       e;
    logic       mem_op;
    logic [7:0] eret;
    logic [7:0] nxt;
    mem_op = (op == 4'h2) || (op == 4'h3);
    if (op != 4'hF) begin
      e.sel = esel; e.rf = erf; e.alu = ealu;
      exp_q.push_back(e);
    end
    @(negedge clk);
    opcode = op; zf = z; cf = c; pc_cur = pc; mem_ready = 1'b1;
    #1;
    check({tag, ":fetch"}, {mem_req, ir_ld, PCCR, halted}, 4'b1100);
    @(negedge clk);
    #1;
    eret = (stk_m.size() > 0) ? stk_m[$] : 8'h00;
    check({tag, ":decode"}, {PCCR, ir_ld, alu_en, mem_req, rf_we}, 0);
    check({tag, ":ret_addr"}, ret_addr, eret);
    check({tag, ":stk_err_pre"}, stk_err, err_m);
    @(negedge clk);
    if (mem_op && waits > 0) mem_ready = 1'b0;
    #1;
    if (mem_op) begin
      check({tag, ":exec_mem"}, {PCCR, mem_req, rf_we}, 0);
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check({tag, ":mem_wait"}, {mem_req, PCCR, rf_we}, 3'b100);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check({tag, ":mem_req_rdy"}, mem_req, 1);
      pccr_pop(tag);
    end else if (op == 4'hF) begin
      check({tag, ":exec_hlt"}, {PCCR, halted}, 0);
    end else begin
      check({tag, ":exec_mem_req"}, mem_req, 0);
      pccr_pop(tag);
    end
    nxt = pc + 8'd1;
    if (op == 4'h7) begin
      if (stk_m.size() < DEPTH) stk_m.push_back(nxt);
      else err_m = 1'b1;
    end else if (op == 4'h8) begin
      if (stk_m.size() > 0) void'(stk_m.pop_back());
      else err_m = 1'b1;
    end
  endtask

  initial begin
    int pccr_cnt;
    int halt_miss;
    rst = 1'b0; opcode = 4'h0; zf = 1'b0; cf = 1'b0; mem_ready = 1'b0; pc_cur = 8'h00;
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("por");
    do_reset("rst0");

    // ALU back to back: PCCR every 3 cycles
    do_instr("alu1", 4'h1, 0, 0, 8'h00, 0, 2'b00, 1, 1);
    do_instr("alu2", 4'h1, 0, 0, 8'h01, 0, 2'b00, 1, 1);
    do_instr("nop",  4'h0, 0, 0, 8'h02, 0, 2'b00, 0, 0);
    do_instr("op9",  4'h9, 1, 1, 8'h03, 0, 2'b00, 0, 0);
    do_instr("ld_w2", 4'h2, 0, 0, 8'h04, 2, 2'b00, 1, 0);
    do_instr("st_w0", 4'h3, 0, 0, 8'h05, 0, 2'b00, 0, 0);
    do_instr("jmp",  4'h4, 0, 0, 8'h06, 0, 2'b01, 0, 0);
    do_instr("jz1",  4'h5, 1, 0, 8'h07, 0, 2'b01, 0, 0);
    do_instr("jz0",  4'h5, 0, 1, 8'h08, 0, 2'b00, 0, 0);
    do_instr("jc1",  4'h6, 0, 1, 8'h09, 0, 2'b01, 0, 0);
    do_instr("jc0",  4'h6, 1, 0, 8'h0A, 0, 2'b00, 0, 0);

    // CALL/RET including address wrap
    do_instr("call10", 4'h7, 0, 0, 8'h10, 0, 2'b01, 0, 0);
    @(posedge clk);
    #1;
    check("call10:top", ret_addr, 8'h11);
    do_instr("callff", 4'h7, 0, 0, 8'hFF, 0, 2'b01, 0, 0);
    do_instr("ret_a",  4'h8, 0, 0, 8'h00, 0, 2'b10, 0, 0);
    do_instr("ret_b",  4'h8, 0, 0, 8'h01, 0, 2'b10, 0, 0);

    // Overflow: fifth CALL rejected
    for (int i = 0; i < 4; i++)
      do_instr($sformatf("call_%0d", i), 4'h7, 0, 0, 8'h20 + 8'(i), 0, 2'b01, 0, 0);
    do_instr("call_ovf", 4'h7, 0, 0, 8'h30, 0, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++)
      do_instr($sformatf("ret_%0d", i), 4'h8, 0, 0, 8'h40, 0, 2'b10, 0, 0);
    do_instr("ret_empty_sticky", 4'h8, 0, 0, 8'h41, 0, 2'b00, 0, 0);
    do_instr("nop_err_sticky", 4'h0, 0, 0, 8'h42, 0, 2'b00, 0, 0);

    // Reset during a MEM wait: no PCCR
    @(negedge clk);
    opcode = 4'h2; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mem:waiting", {mem_req, PCCR}, 2'b10);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    check_quiet("rst_mem:in_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mem:first_fetch", {mem_req, PCCR, stk_err}, 3'b100);
    stk_m.delete();
    err_m = 1'b0;

    // RET on empty stack after reset raises stk_err fresh
    do_instr("ret_empty", 4'h8, 0, 0, 8'h50, 0, 2'b00, 0, 0);
    do_instr("alu_after_err", 4'h1, 0, 0, 8'h51, 0, 2'b00, 1, 1);

    // HLT: halted and no PCCR for 20 cycles, then reset
    do_instr("hlt", 4'hF, 0, 0, 8'h52, 0, 2'b00, 0, 0);
    pccr_cnt = 0;
    halt_miss = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (PCCR) pccr_cnt++;
      if (!halted || ir_ld || mem_req || alu_en || rf_we) halt_miss++;
    end
    check("halt:pccr_count", pccr_cnt, 0);
    check("halt:state_miss", halt_miss, 0);
    do_reset("rst_halt");
    do_instr("alu_post", 4'h1, 0, 0, 8'h60, 0, 2'b00, 1, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
